// File: rtl/switch_pkg.sv
// ============================================================================
// switch_pkg: shared constants and state encoding for the switch debouncer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package switch_pkg;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 160000;
   localparam int SYNC_FLOPS              = 2;

   typedef enum logic [0:0] {
      DB_IDLE  = 1'b0,
      DB_COUNT = 1'b1
   } db_state_t;

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
// debounce_bit: synchronizer, hold counter and accepted level for one switch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module debounce_bit
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_n,
   output logic stable,
   output logic commit,
   output logic counting
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_FLOPS-1:0] sync_q;
   logic                  sync2;
   db_state_t             state;
   db_state_t             state_next;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_next;
   logic                  stable_next;
   logic                  diff;

   // Sync chain resets to 1 so an idle (released) switch produces no edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_FLOPS-2:0], sw_n};
      end
   end

   assign sync2 = sync_q[SYNC_FLOPS-1];
   assign diff  = (sync2 != stable);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= DB_IDLE;
         cnt    <= '0;
         stable <= 1'b1;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         stable <= stable_next;
      end
   end

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      stable_next = stable;
      commit      = 1'b0;
      case (state)
         DB_IDLE: begin
            cnt_next = '0;
            if (diff) begin
               // Entering COUNT already accounts for the first differing cycle.
               state_next = DB_COUNT;
               cnt_next   = CW'(1);
            end
         end
         DB_COUNT: begin
            if (!diff) begin
               state_next = DB_IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_MAX) begin
               state_next  = DB_IDLE;
               cnt_next    = '0;
               stable_next = sync2;
               commit      = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            state_next = DB_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign counting = (state == DB_COUNT);

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
// switch_debouncer: per-bit debounced, active-high switch operands with update
// strobe. Revision: 1.0
// ============================================================================
`default_nettype none

module switch_debouncer
   import switch_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] sw_n,
   output logic [WIDTH-1:0] data,
   output logic             upd,
   output logic             busy
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] commit;
   logic [WIDTH-1:0] counting;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bits
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk      (CLK),
         .rst_n    (RST_N),
         .sw_n     (sw_n[i]),
         .stable   (stable[i]),
         .commit   (commit[i]),
         .counting (counting[i])
      );
   end

   // Registered so the strobe lines up with the cycle the new data appears.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         upd <= 1'b0;
      end else begin
         upd <= |commit;
      end
   end

   assign data = ~stable;
   assign busy = |counting;

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity,
// checked every cycle against a run-length model of the debounce rule.
`default_nettype none

module tb_switch_debouncer;

   localparam int WIDTH = 8;
   localparam int D     = 8;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic [WIDTH-1:0] sw_n;
   logic [WIDTH-1:0] data;
   logic             upd;
   logic             busy;

   always #5 CLK = ~CLK;

   switch_debouncer #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .sw_n  (sw_n),
      .data  (data),
      .upd   (upd),
      .busy  (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: a 2-deep delay line feeds each bit; a level that differs from the
   // accepted one for D consecutive edges is accepted on the D-th edge.
   logic [WIDTH-1:0] m_s1, m_s2, m_stable;
   int               m_run [WIDTH];
   logic             m_upd;

   task automatic model_reset();
      m_s1     = '1;
      m_s2     = '1;
      m_stable = '1;
      m_upd    = 1'b0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
   endtask

   task automatic model_edge(input logic [WIDTH-1:0] sw);
      logic [WIDTH-1:0] acc;
      acc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (m_s2[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               acc[i]   = 1'b1;
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_stable = m_stable ^ acc;
      m_upd    = |acc;
      m_s2     = m_s1;
      m_s1     = sw;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [WIDTH-1:0] exp_data;
      logic             exp_busy;
      exp_data = ~m_stable;
      exp_busy = 1'b0;
      for (int i = 0; i < WIDTH; i++) if (m_run[i] != 0) exp_busy = 1'b1;
      chk({tag, ".data"}, 32'(data), 32'(exp_data));
      chk({tag, ".upd"},  32'(upd),  32'(m_upd));
      chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
   endtask

   task automatic step(input logic [WIDTH-1:0] sw, input string tag);
      sw_n = sw;
      @(posedge CLK);
      model_edge(sw);
      #1;
      check_model(tag);
   endtask

   logic [4:0] sum;
   assign sum = {1'b0, data[3:0]} + {1'b0, data[7:4]};

   int first_seen;
   int upd_cnt;

   initial begin
      model_reset();
      RST_N = 1'b0;
      sw_n  = '1;

      // Reset values
      repeat (3) @(posedge CLK);
      #1;
      chk("reset.data", 32'(data), 32'h00);
      chk("reset.upd",  32'(upd),  32'h0);
      chk("reset.busy", 32'(busy), 32'h0);
      RST_N = 1'b1;
      upd_cnt = 0;
      for (int e = 0; e < 50; e++) begin
         step(8'hFF, "idle");
         if (upd) upd_cnt++;
      end
      chk("idle.upd_count", 32'(upd_cnt), 32'd0);

      // Clean press on bit 0; step 0 is the first sampling edge
      first_seen = -1;
      upd_cnt    = 0;
      for (int e = 0; e < 16; e++) begin
         step(8'hFE, "press");
         if (data[0] && first_seen < 0) first_seen = e;
         if (upd) upd_cnt++;
         if (e == 1) chk("press.busy_e1", 32'(busy), 32'h0);
         if (e == 2) chk("press.busy_e2", 32'(busy), 32'h1);
         if (e == 8) chk("press.busy_e8", 32'(busy), 32'h1);
         if (e == 9) chk("press.busy_e9", 32'(busy), 32'h0);
      end
      chk("press.latency",   32'(first_seen), 32'(D + 1));
      chk("press.upd_count", 32'(upd_cnt),    32'd1);
      chk("press.data",      32'(data),       32'h01);

      // Bounce rejection on bit 3 while bit 0 stays pressed
      upd_cnt = 0;
      repeat (4) begin
         for (int e = 0; e < 5; e++) begin
            step(8'hF6, "bounce_lo");
            if (upd) upd_cnt++;
         end
         for (int e = 0; e < 5; e++) begin
            step(8'hFE, "bounce_hi");
            if (upd) upd_cnt++;
         end
      end
      chk("bounce.upd_count", 32'(upd_cnt), 32'd0);
      chk("bounce.data",      32'(data),    32'h01);
      first_seen = -1;
      for (int e = 0; e < 20; e++) begin
         step(8'hF6, "bounce_hold");
         if (data[3] && first_seen < 0) first_seen = e;
      end
      chk("bounce.latency", 32'(first_seen), 32'(D + 1));
      chk("bounce.data_end", 32'(data), 32'h09);

      // Simultaneous commit of the upper nibble
      for (int e = 0; e < 12; e++) step(8'hFF, "release");
      chk("release.data", 32'(data), 32'h00);
      upd_cnt = 0;
      for (int e = 0; e < 15; e++) begin
         step(8'h0F, "simul");
         if (upd) upd_cnt++;
      end
      chk("simul.upd_count", 32'(upd_cnt), 32'd1);
      chk("simul.data",      32'(data),    32'hF0);

      // Reset mid-count: press bit 0, reset at count cycle 5
      for (int e = 0; e <= 6; e++) step(8'h0E, "midcnt");
      chk("midcnt.busy_before", 32'(busy), 32'h1);
      RST_N = 1'b0;
      #1;
      model_reset();
      chk("midcnt.async_data", 32'(data), 32'h00);
      chk("midcnt.async_busy", 32'(busy), 32'h0);
      chk("midcnt.async_upd",  32'(upd),  32'h0);
      repeat (3) begin
         @(posedge CLK);
         #1;
         check_model("in_reset");
      end
      RST_N = 1'b1;
      first_seen = -1;
      for (int e = 0; e < 14; e++) begin
         step(8'h0E, "post_reset");
         if (data[0] && first_seen < 0) first_seen = e;
      end
      chk("post_reset.latency", 32'(first_seen), 32'(D + 1));
      chk("post_reset.data",    32'(data),       32'hF1);

      // Adder end-to-end: A = 5, B = 3
      for (int e = 0; e < 14; e++) step(8'hCA, "adder");
      chk("adder.sum",   32'(sum[3:0]), 32'd8);
      chk("adder.carry", 32'(sum[4]),   32'd0);

      // Random activity with mixed hold lengths
      for (int seg = 0; seg < 60; seg++) begin
         logic [WIDTH-1:0] v;
         int               hold;
         v    = WIDTH'($urandom);
         hold = int'($urandom_range(1, 14));
         for (int e = 0; e < hold; e++) step(v, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
